// File: rtl/n64_poll_apb.sv
// APB3 peripheral that polls an N64 controller with command 0x01 over the open-drain
// data line and latches the returned 32-bit button/joystick word for firmware.
module n64_poll_apb #(
    parameter int unsigned CYC_PER_US    = 100,
    parameter int unsigned POLL_PERIOD   = 1000000,
    parameter int unsigned RX_TIMEOUT_US = 100
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        n64_in,
    output logic        n64_oe,
    output logic        poll_done
);

    localparam int unsigned BIT_CYC    = 4 * CYC_PER_US;
    localparam int unsigned SAMPLE_CYC = 2 * CYC_PER_US;
    localparam int unsigned TO_CYC     = RX_TIMEOUT_US * CYC_PER_US;
    localparam logic [7:0]  CMD        = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE, S_TX_BIT, S_TX_STOP, S_RX_WAIT, S_RX_SAMPLE, S_RX_STOP, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic [31:0] r_timer;
    logic [31:0] r_poll_cnt;
    logic [5:0]  r_bitcnt;
    logic [31:0] r_shift;
    logic [31:0] r_data;
    logic [15:0] r_count;
    logic        r_auto;
    logic        r_valid;
    logic        r_timeout;
    logic        r_oe;
    logic        r_done;
    logic        r_seen;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;

    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_wrap;
    logic        w_busy;
    logic        w_line;
    logic        w_fall;
    logic        w_cmd_bit;
    logic [31:0] w_hi_len;
    logic        w_unused;

    assign w_ctrl_wr = PSEL & PENABLE & PWRITE & (PADDR[7:0] == 8'h00);
    assign w_start   = w_ctrl_wr & PWDATA[1];
    assign w_wrap    = r_auto && (r_poll_cnt == POLL_PERIOD - 1);
    assign w_busy    = (r_state != S_IDLE);
    assign w_line    = r_sync2;
    assign w_fall    = r_prev & ~r_sync2;
    assign w_cmd_bit = CMD[3'd7 - r_bitcnt[2:0]];
    assign w_hi_len  = w_cmd_bit ? CYC_PER_US : 3 * CYC_PER_US;
    assign w_unused  = ^{PADDR[31:8], PWDATA[31:2]};

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign n64_oe    = r_oe;
    assign poll_done = r_done;

    always_comb begin
        PRDATA = '0;
        case (PADDR[7:0])
            8'h00:   PRDATA = {31'd0, r_auto};
            8'h04:   PRDATA = {r_count, 13'd0, r_timeout, r_valid, w_busy};
            8'h08:   PRDATA = r_data;
            default: PRDATA = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= n64_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN || !r_auto || w_wrap) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 32'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_count   <= '0;
            r_auto    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_seen    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_ctrl_wr) r_auto <= PWDATA[0];
            case (r_state)
                S_IDLE: begin
                    if (w_start || w_wrap) begin
                        r_state  <= S_TX_BIT;
                        r_timer  <= '0;
                        r_bitcnt <= '0;
                        r_oe     <= 1'b1;
                    end
                end
                // oe is registered, so it is computed from the timer value of the next cycle
                S_TX_BIT: begin
                    if (r_timer == BIT_CYC - 1) begin
                        r_timer <= '0;
                        r_oe    <= 1'b1;
                        if (r_bitcnt == 6'd7) r_state <= S_TX_STOP;
                        else r_bitcnt <= r_bitcnt + 6'd1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                        r_oe    <= (r_timer + 32'd1 < w_hi_len);
                    end
                end
                S_TX_STOP: begin
                    if (r_timer == CYC_PER_US - 1) begin
                        r_state  <= S_RX_WAIT;
                        r_timer  <= '0;
                        r_bitcnt <= '0;
                        r_oe     <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_RX_WAIT: begin
                    if (w_fall) begin
                        r_state <= S_RX_SAMPLE;
                        r_timer <= '0;
                    end else if (r_timer == TO_CYC - 1) begin
                        r_state <= S_ERR;
                        r_done  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_RX_SAMPLE: begin
                    if (r_timer == SAMPLE_CYC - 1) begin
                        r_shift <= {r_shift[30:0], w_line};
                        r_timer <= '0;
                        if (r_bitcnt == 6'd31) begin
                            r_state <= S_RX_STOP;
                            r_seen  <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                            r_state  <= S_RX_WAIT;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_RX_STOP: begin
                    if ((r_seen && w_line) || (r_timer == BIT_CYC - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                        if (w_fall) r_seen <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_data    <= r_shift;
                    r_valid   <= 1'b1;
                    r_timeout <= 1'b0;
                    r_count   <= r_count + 16'd1;
                    r_state   <= S_IDLE;
                end
                S_ERR: begin
                    r_valid   <= 1'b0;
                    r_timeout <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_poll_apb.sv
// Directed bench for n64_poll_apb with an open-drain controller model on the data line.
// Line timing is scaled (CYC_PER_US=20, POLL_PERIOD=8000) to keep the run short.
module tb_n64_poll_apb;

    localparam int unsigned C   = 20;
    localparam int unsigned P   = 8000;
    localparam int unsigned TOU = 100;
    localparam int unsigned TO  = TOU * C;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        n64_in;
    logic        n64_oe;
    logic        poll_done;
    logic        ctl_low = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc = 0;

    assign n64_in = ~(n64_oe | ctl_low);

    n64_poll_apb #(.CYC_PER_US(C), .POLL_PERIOD(P), .RX_TIMEOUT_US(TOU)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .n64_in(n64_in), .n64_oe(n64_oe), .poll_done(poll_done)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) if (poll_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1;
        d = PRDATA;
        PSEL = 1'b0;
    endtask

    // Controller reply: '0' = 3us low/1us high, '1' = 1us low/3us high, MSB first.
    task automatic respond(input logic [31:0] w, input int unsigned nb, input bit stop);
        logic b;
        repeat (2 * C) tick();
        for (int unsigned i = 0; i < nb; i++) begin
            b = w[31 - i];
            ctl_low = 1'b1;
            repeat (b ? C : 3 * C) tick();
            ctl_low = 1'b0;
            repeat (b ? 3 * C : C) tick();
        end
        if (stop) begin
            ctl_low = 1'b1;
            repeat (C) tick();
            ctl_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int unsigned bound, output int unsigned n);
        n = 0;
        while (poll_done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0]  rd;
        int unsigned  n;
        int unsigned  err;
        int unsigned  hi;
        int           d0;
        int           c1;

        // T1 reset
        repeat (5) tick();
        check("rst_oe", {31'd0, n64_oe}, 32'd0);
        check("rst_done", {31'd0, poll_done}, 32'd0);
        check("pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'h2);
        apb_read(32'h0, rd); check("rst_ctrl", rd, 32'h0);
        apb_read(32'h4, rd); check("rst_status", rd, 32'h0);
        apb_read(32'h8, rd); check("rst_data", rd, 32'h0);
        PRESERN = 1'b1;
        tick();

        // T2 TX waveform of command 0x01 plus stop
        d0 = done_cnt;
        apb_write(32'h0, 32'h2);
        apb_read(32'h4, rd); check("busy_after_start", rd, 32'h1);
        apb_read(32'h0, rd); check("start_reads_0", rd, 32'h0);
        for (int b = 0; b < 8; b++) begin
            hi = (b == 7) ? C : 3 * C;
            err = 0;
            for (int unsigned t = 0; t < 4 * C; t++) begin
                if (n64_oe !== (t < hi)) err++;
                tick();
            end
            check($sformatf("tx_bit%0d_errs", b), err, 32'd0);
        end
        err = 0;
        for (int unsigned t = 0; t < C; t++) begin
            if (n64_oe !== 1'b1) err++;
            tick();
        end
        check("tx_stop_errs", err, 32'd0);
        check("tx_release", {31'd0, n64_oe}, 32'd0);

        // T3 happy path
        respond(32'h8000_7F81, 32, 1'b1);
        wait_done(20 * C, n);
        check("t3_done_seen", {31'd0, poll_done}, 32'd1);
        repeat (2) tick();
        check("t3_done_once", done_cnt - d0, 32'd1);
        apb_read(32'h8, rd); check("t3_data", rd, 32'h8000_7F81);
        apb_read(32'h4, rd); check("t3_status", rd, 32'h0001_0002);

        // T4 no response: timeout after TO cycles from release; count carried from T3
        apb_write(32'h0, 32'h2);
        repeat (33 * C) tick();
        check("t4_release", {31'd0, n64_oe}, 32'd0);
        wait_done(TO + 100, n);
        check("t4_timeout_latency", n, TO);
        repeat (2) tick();
        apb_read(32'h4, rd); check("t4_status", rd, 32'h0001_0004);
        apb_read(32'h8, rd); check("t4_data_kept", rd, 32'h8000_7F81);

        // T5 abort after 17 bits, then a good poll
        apb_write(32'h0, 32'h2);
        repeat (33 * C) tick();
        respond(32'hA5A5_5A5A, 17, 1'b0);
        wait_done(TO + 200, n);
        check("t5_abort_done", {31'd0, poll_done}, 32'd1);
        repeat (2) tick();
        apb_read(32'h4, rd); check("t5_abort_status", rd, 32'h0001_0004);
        apb_read(32'h8, rd); check("t5_abort_data", rd, 32'h8000_7F81);
        apb_write(32'h0, 32'h2);
        repeat (33 * C) tick();
        respond(32'h1234_5678, 32, 1'b1);
        wait_done(20 * C, n);
        check("t5_good_done", {31'd0, poll_done}, 32'd1);
        repeat (2) tick();
        apb_read(32'h4, rd); check("t5_good_status", rd, 32'h0002_0002);
        apb_read(32'h8, rd); check("t5_good_data", rd, 32'h1234_5678);

        // T6 auto polling, dropped mid-poll START, reset mid-poll
        d0 = done_cnt;
        apb_write(32'h0, 32'h1);
        n = 0;
        while (n64_oe !== 1'b1 && n < 2 * P) begin
            tick();
            n++;
        end
        check("t6_first_launch", n, P);
        repeat (200) tick();
        apb_write(32'h0, 32'h3);
        apb_read(32'h0, rd); check("t6_auto_kept", rd, 32'h1);
        wait_done(P, n);
        check("t6_done1", {31'd0, poll_done}, 32'd1);
        c1 = cyc;
        tick();
        wait_done(2 * P, n);
        check("t6_done2", {31'd0, poll_done}, 32'd1);
        check("t6_period", cyc - c1, P);
        tick();
        check("t6_start_dropped", done_cnt - d0, 32'd2);
        n = 0;
        while (n64_oe !== 1'b1 && n < 2 * P) begin
            tick();
            n++;
        end
        repeat (100) tick();
        check("t6_pre_reset_drive", {31'd0, n64_oe}, 32'd1);
        PRESERN = 1'b0;
        tick();
        check("t6_reset_oe", {31'd0, n64_oe}, 32'd0);
        check("t6_reset_done", {31'd0, poll_done}, 32'd0);
        apb_read(32'h0, rd); check("t6_reset_ctrl", rd, 32'h0);
        apb_read(32'h4, rd); check("t6_reset_status", rd, 32'h0);
        apb_read(32'h8, rd); check("t6_reset_data", rd, 32'h0);
        PRESERN = 1'b1;
        err = 0;
        for (int unsigned t = 0; t < P + 100; t++) begin
            if (n64_oe !== 1'b0) err++;
            tick();
        end
        check("t6_no_auto_after_reset", err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
